// File: rtl/rx_tl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rx_tl_pkg
// Brief    : Shared types, header bit positions and decode helpers for the
//            receive transaction layer.
// Revision : 1.0 - initial release
// ============================================================================
package rx_tl_pkg;

  // Header bit positions within the TLP bus
  localparam int HDR_MSB  = 607;
  localparam int FMT_LSB  = 605;
  localparam int TYPE_LSB = 600;
  localparam int TC_LSB   = 596;
  localparam int LEN_LSB  = 576;
  localparam int REQ_LSB  = 560;
  localparam int CPL_LSB  = 528;
  localparam int ADDR_LSB = 514;
  localparam int PAY_W    = 512;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  tlp_type;
    logic [2:0]  tc;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [15:0] cpl_id;
    logic [31:0] addr;
  } tlp_hdr_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_e;

  // Width of a VC index; never narrower than one bit
  function automatic int vc_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Pull the header fields out of the low part of a TLP
  function automatic tlp_hdr_t decode_hdr(input logic [HDR_MSB:0] t);
    tlp_hdr_t h;
    h.fmt      = t[FMT_LSB  +: 3];
    h.tlp_type = t[TYPE_LSB +: 5];
    h.tc       = t[TC_LSB   +: 3];
    h.len      = t[LEN_LSB  +: 10];
    h.req_id   = t[REQ_LSB  +: 16];
    h.cpl_id   = t[CPL_LSB  +: 16];
    h.addr     = {t[ADDR_LSB +: 30], 2'b00};
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/SAL_FIFO.sv
`default_nettype none
// ============================================================================
// Module   : SAL_FIFO
// Brief    : Synchronous first-word-fall-through FIFO. Head entry is visible
//            on data_o whenever empty_o is low. Push when full and pop when
//            empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module SAL_FIFO #(
  parameter int W         = 8,
  parameter int DEPTH_LG2 = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int CW    = DEPTH_LG2 + 1;

  logic [W-1:0]         mem_q [DEPTH];
  logic [DEPTH_LG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (cnt_q == '0);
  assign full_o  = cnt_q[DEPTH_LG2];
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LG2'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_tl_wrr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rx_tl_wrr_arb
// Brief    : Credit-based weighted round-robin arbiter. Grant is
//            combinational so a VC switch costs no bubble; the pointer and
//            credits update only on a pop.
// Revision : 1.0 - initial release
// ============================================================================
module rx_tl_wrr_arb
  import rx_tl_pkg::*;
#(
  parameter int  N_VC     = 4,
  parameter int  WGT_W    = 4,
  localparam int VC_IDX_W = vc_idx_w(N_VC)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_VC-1:0]         valid_i,
  input  logic                    pop_en_i,
  input  logic [N_VC*WGT_W-1:0]   weight_i,
  output logic [VC_IDX_W-1:0]     gnt_vc_o,
  output logic                    gnt_valid_o,
  output logic                    pop_o
);
  arb_state_e                 state_q, state_d;
  logic [VC_IDX_W-1:0]        cur_vc_q, cur_vc_d, next_vc;
  logic [N_VC-1:0][WGT_W-1:0] credit_q, credit_d;
  logic [WGT_W-1:0]           reload_wgt;
  logic                       stay, found;
  int                         start, idx;

  // Pick the grant, then advance pointer/credits/state when a pop happens
  always_comb begin
    state_d    = state_q;
    cur_vc_d   = cur_vc_q;
    credit_d   = credit_q;
    found      = 1'b0;
    next_vc    = '0;
    idx        = 0;
    // Keep serving the current VC while it has data and credit left
    stay       = valid_i[cur_vc_q] && (credit_q[cur_vc_q] != '0);
    // From idle the current VC is eligible first; when serving, search past it
    start      = int'(cur_vc_q) + ((state_q == ST_SERVE) ? 1 : 0);
    for (int k = 0; k < N_VC; k++) begin
      idx = (start + k) % N_VC;
      if (!found && valid_i[idx]) begin
        found   = 1'b1;
        next_vc = VC_IDX_W'(idx);
      end
    end
    gnt_valid_o = |valid_i;
    gnt_vc_o    = stay ? cur_vc_q : next_vc;
    pop_o       = pop_en_i && gnt_valid_o;
    reload_wgt  = weight_i[int'(next_vc)*WGT_W +: WGT_W];
    if (pop_o) begin
      state_d = ST_SERVE;
      if (stay) begin
        credit_d[cur_vc_q] = credit_q[cur_vc_q] - WGT_W'(1);
      end else begin
        // Reload consumes one unit for this pop; weight 0 behaves as 1
        cur_vc_d          = next_vc;
        credit_d[next_vc] = (reload_wgt == '0) ? '0 : reload_wgt - WGT_W'(1);
      end
    end else if (!gnt_valid_o) begin
      state_d = ST_IDLE;
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cur_vc_q <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_vc_q <= cur_vc_d;
      credit_q <= credit_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_tl_vc_arb_depkt.sv
`default_nettype none
// ============================================================================
// Module   : rx_tl_vc_arb_depkt
// Brief    : Receive transaction layer. Steers TLPs by TC through a TC->VC
//            map into per-VC FWFT FIFOs, drains them with a weighted
//            round-robin arbiter and decodes header/payload into a
//            registered valid/ready output stage.
// Options  : RX_TL_STATS_EN - per-VC 16-bit saturating accept counters.
// Revision : 1.0 - initial release
// ============================================================================
module rx_tl_vc_arb_depkt
  import rx_tl_pkg::*;
#(
  parameter int  N_VC      = 4,
  parameter int  TLP_W     = 1024,
  parameter int  DEPTH_LG2 = 4,
  parameter int  WGT_W     = 4,
  localparam int VC_IDX_W  = vc_idx_w(N_VC)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [TLP_W-1:0]       tlp_data_i,
  input  logic                   tlp_valid_i,
  output logic                   tlp_ready_o,
  input  logic [8*VC_IDX_W-1:0]  cfg_tc_map_i,
  input  logic [N_VC*WGT_W-1:0]  cfg_weight_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [VC_IDX_W-1:0]    out_vc_o,
  output logic [2:0]             hdr_fmt_o,
  output logic [4:0]             hdr_type_o,
  output logic [2:0]             hdr_tc_o,
  output logic [9:0]             hdr_len_o,
  output logic [15:0]            hdr_req_id_o,
  output logic [15:0]            hdr_cpl_id_o,
  output logic [31:0]            addr_o,
  output logic [511:0]           data_o,
  output logic [N_VC*16-1:0]     stat_cnt_o
);
  localparam int ENT_W = HDR_MSB + 1;

  logic [VC_IDX_W-1:0] map_raw, sel_vc, gnt_vc, out_vc_q;
  logic                accept, gnt_valid, arb_pop, pop_en, out_valid_q;
  logic [N_VC-1:0]     fifo_full, fifo_empty;
  logic [ENT_W-1:0]    fifo_dout [N_VC];
  tlp_hdr_t            gnt_hdr, hdr_q;
  logic [PAY_W-1:0]    data_q;
  logic                unused_bits;

  // Resolve the destination VC of the TLP on the input bus, clamping bad map entries
  always_comb begin
    map_raw = cfg_tc_map_i[int'(tlp_data_i[TC_LSB +: 3])*VC_IDX_W +: VC_IDX_W];
    sel_vc  = map_raw;
    if (int'(map_raw) >= N_VC) sel_vc = VC_IDX_W'(N_VC - 1);
  end

  // Ready follows only the target FIFO's full flag: no bypass through a same-cycle pop
  assign tlp_ready_o = !fifo_full[sel_vc];
  assign accept      = tlp_valid_i && tlp_ready_o;
  assign pop_en      = !out_valid_q || out_ready_i;
  assign gnt_hdr     = decode_hdr(fifo_dout[gnt_vc]);
  assign unused_bits = ^{tlp_data_i[TLP_W-1:ENT_W], gnt_valid};

  for (genvar g = 0; g < N_VC; g++) begin : g_vc_fifo
    SAL_FIFO #(
      .W         (ENT_W),
      .DEPTH_LG2 (DEPTH_LG2)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (accept && (sel_vc == VC_IDX_W'(g))),
      .data_i  (tlp_data_i[ENT_W-1:0]),
      .pop_i   (arb_pop && (gnt_vc == VC_IDX_W'(g))),
      .data_o  (fifo_dout[g]),
      .empty_o (fifo_empty[g]),
      .full_o  (fifo_full[g])
    );
  end

  rx_tl_wrr_arb #(
    .N_VC  (N_VC),
    .WGT_W (WGT_W)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_i     (~fifo_empty),
    .pop_en_i    (pop_en),
    .weight_i    (cfg_weight_i),
    .gnt_vc_o    (gnt_vc),
    .gnt_valid_o (gnt_valid),
    .pop_o       (arb_pop)
  );

  // Output stage: load on pop, hold while stalled, drop valid once consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      hdr_q       <= '0;
      data_q      <= '0;
    end else if (arb_pop) begin
      out_valid_q <= 1'b1;
      out_vc_q    <= gnt_vc;
      hdr_q       <= gnt_hdr;
      data_q      <= fifo_dout[gnt_vc][PAY_W-1:0];
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_vc_o     = out_vc_q;
  assign hdr_fmt_o    = hdr_q.fmt;
  assign hdr_type_o   = hdr_q.tlp_type;
  assign hdr_tc_o     = hdr_q.tc;
  assign hdr_len_o    = hdr_q.len;
  assign hdr_req_id_o = hdr_q.req_id;
  assign hdr_cpl_id_o = hdr_q.cpl_id;
  assign addr_o       = hdr_q.addr;
  assign data_o       = data_q;

`ifdef RX_TL_STATS_EN
  for (genvar g = 0; g < N_VC; g++) begin : g_stat
    logic [15:0] cnt_q;
    // Count accepts steered into this VC, sticking at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (accept && (sel_vc == VC_IDX_W'(g)) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign stat_cnt_o[g*16 +: 16] = cnt_q;
  end
`else
  assign stat_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_tl_vc_arb_depkt.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_tl_vc_arb_depkt
// Brief    : Directed self-checking bench for rx_tl_vc_arb_depkt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_tl_vc_arb_depkt;
  localparam int N_VC = 4, TLP_W = 1024, DEPTH_LG2 = 4, WGT_W = 4, VC_IDX_W = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [TLP_W-1:0]      tlp_data_i;
  logic                  tlp_valid_i, tlp_ready_o;
  logic [8*VC_IDX_W-1:0] cfg_tc_map_i;
  logic [N_VC*WGT_W-1:0] cfg_weight_i;
  logic                  out_valid_o, out_ready_i;
  logic [VC_IDX_W-1:0]   out_vc_o;
  logic [2:0]            hdr_fmt_o, hdr_tc_o;
  logic [4:0]            hdr_type_o;
  logic [9:0]            hdr_len_o;
  logic [15:0]           hdr_req_id_o, hdr_cpl_id_o;
  logic [31:0]           addr_o;
  logic [511:0]          data_o;
  logic [N_VC*16-1:0]    stat_cnt_o;
  logic [TLP_W-1:0]      t;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_vc [16] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};

  rx_tl_vc_arb_depkt #(
    .N_VC(N_VC), .TLP_W(TLP_W), .DEPTH_LG2(DEPTH_LG2), .WGT_W(WGT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tlp_data_i(tlp_data_i), .tlp_valid_i(tlp_valid_i),
    .tlp_ready_o(tlp_ready_o), .cfg_tc_map_i(cfg_tc_map_i), .cfg_weight_i(cfg_weight_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_vc_o(out_vc_o),
    .hdr_fmt_o(hdr_fmt_o), .hdr_type_o(hdr_type_o), .hdr_tc_o(hdr_tc_o), .hdr_len_o(hdr_len_o),
    .hdr_req_id_o(hdr_req_id_o), .hdr_cpl_id_o(hdr_cpl_id_o), .addr_o(addr_o),
    .data_o(data_o), .stat_cnt_o(stat_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TLP_W-1:0] mk(input logic [2:0] tc, input int tag);
    logic [TLP_W-1:0] v;
    v = '0;
    v[598:596] = tc;
    v[585:576] = 10'h001;
    v[31:0]    = 32'(tag);
    return v;
  endfunction

  function automatic logic [511:0] pl(input int tag);
    logic [511:0] p;
    p = '0;
    p[31:0] = 32'(tag);
    return p;
  endfunction

  initial begin
    reset_n      = 1'b0;
    tlp_valid_i  = 1'b0;
    tlp_data_i   = '0;
    out_ready_i  = 1'b0;
    cfg_tc_map_i = '0;
    cfg_weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    repeat (2) tick();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_ready", tlp_ready_o, 1);
    chk("rst_vc", out_vc_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_addr", addr_o, 0);
    reset_n = 1'b1;
    tick();
    chk("rel_ready", tlp_ready_o, 1);

    // All TCs on VC0, 16 TLPs streamed with consumer always ready
    cfg_tc_map_i = 16'h0000;
    out_ready_i  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tlp_valid_i = (i < 16);
      tlp_data_i  = mk(3'(i % 8), i);
      #1;
      if (i < 16) chk("t1_ready", tlp_ready_o, 1);
      tick();
      if (i >= 1) begin
        chk("t1_valid", out_valid_o, 1);
        chk("t1_vc", out_vc_o, 0);
        chk("t1_data", data_o, pl(i - 1));
      end
    end
    tick();
    chk("t1_drained", out_valid_o, 0);

    // Consumer stalled: 16 in FIFO plus one in the output register
    out_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tlp_valid_i = 1'b1;
      tlp_data_i  = mk(3'd0, 200 + i);
      #1;
      chk("t3_ready", tlp_ready_o, 1);
      tick();
    end
    tlp_data_i = mk(3'd0, 217);
    #1;
    chk("t3_full", tlp_ready_o, 0);
    tick();
    tlp_valid_i = 1'b0;
    chk("t3_hold_valid", out_valid_o, 1);
    chk("t3_hold_data", data_o, pl(200));
    repeat (3) tick();
    chk("t3_stable", data_o, pl(200));
    chk("t3_still_full", tlp_ready_o, 0);
    out_ready_i = 1'b1;
    for (int k = 1; k < 17; k++) begin
      tick();
      chk("t3_drain", data_o, pl(200 + k));
    end
    tick();
    chk("t3_empty", out_valid_o, 0);

    // TC5 steered to VC3 with full header decode
    cfg_tc_map_i = 16'h0000;
    cfg_tc_map_i[11:10] = 2'd3;
    t = '0;
    t[607:605] = 3'b010;
    t[604:600] = 5'h0A;
    t[598:596] = 3'd5;
    t[585:576] = 10'h010;
    t[575:560] = 16'hABCD;
    t[543:514] = 30'h0400_0001;
    t[31:0]    = 32'h44;
    tlp_data_i  = t;
    tlp_valid_i = 1'b1;
    #1;
    chk("t4_ready", tlp_ready_o, 1);
    tick();
    tlp_valid_i = 1'b0;
    chk("t4_latency", out_valid_o, 0);
    tick();
    chk("t4_valid", out_valid_o, 1);
    chk("t4_vc", out_vc_o, 3);
    chk("t4_len", hdr_len_o, 10'h010);
    chk("t4_addr", addr_o, 32'h1000_0004);
    chk("t4_fmt", hdr_fmt_o, 3'b010);
    chk("t4_type", hdr_type_o, 5'h0A);
    chk("t4_tc", hdr_tc_o, 3'd5);
    chk("t4_req", hdr_req_id_o, 16'hABCD);
    chk("t4_cpl", hdr_cpl_id_o, 16'h1000);
    chk("t4_data", data_o, pl(32'h44));
    tick();

    // Reset while five TLPs are queued
    cfg_tc_map_i = 16'h0000;
    out_ready_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tlp_valid_i = 1'b1;
      tlp_data_i  = mk(3'd0, 300 + i);
      tick();
    end
    tlp_valid_i = 1'b0;
    chk("t5_pre_valid", out_valid_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid_o, 0);
    chk("t5_rst_data", data_o, 0);
    chk("t5_rst_ready", tlp_ready_o, 1);
    @(negedge clk);
    reset_n     = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_stale", out_valid_o, 0);
    end
    chk("t5_stat", stat_cnt_o, 0);

    // Weights 3/1 on VC0/VC1, both preloaded with 8 TLPs
    cfg_weight_i = {4'd1, 4'd1, 4'd1, 4'd3};
    cfg_tc_map_i = 16'h0004;
    out_ready_i  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tlp_valid_i = 1'b1;
      tlp_data_i  = (i < 8) ? mk(3'd0, 400 + i) : mk(3'd1, 500 + i - 8);
      #1;
      chk("t2_ready", tlp_ready_o, 1);
      tick();
    end
    tlp_valid_i = 1'b0;
    chk("t2_vc", out_vc_o, exp_vc[0]);
    out_ready_i = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("t2_valid", out_valid_o, 1);
      chk("t2_vc", out_vc_o, exp_vc[k]);
    end
    tick();
    chk("t2_empty", out_valid_o, 0);
`ifdef RX_TL_STATS_EN
    chk("t2_stat", stat_cnt_o, {16'd0, 16'd0, 16'd8, 16'd8});

    // Saturation of the VC1 counter
    reset_n = 1'b0;
    tick();
    reset_n      = 1'b1;
    cfg_tc_map_i = 16'h0004;
    out_ready_i  = 1'b1;
    tlp_valid_i  = 1'b1;
    tlp_data_i   = mk(3'd1, 600);
    repeat (70000) tick();
    tlp_valid_i = 1'b0;
    tick();
    chk("t6_stat", stat_cnt_o, {16'd0, 16'd0, 16'hFFFF, 16'd0});
`else
    chk("t2_stat", stat_cnt_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
